// File: rtl/ram_arbiter_if.sv
// Shared CPU/RAM types and the per-core request / shared-RAM bus bundle
// seen by the dual-core RAM arbiter.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0] dREN;
  logic [CPUS-1:0] dWEN;
  logic [CPUS-1:0] iREN;
  word_t           daddr  [CPUS];
  word_t           dstore [CPUS];
  word_t           iaddr  [CPUS];

  ramstate_t       ramstate;
  word_t           ramload;
  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;

  logic [CPUS-1:0] dwait;
  logic [CPUS-1:0] iwait;
  word_t           dload [CPUS];
  word_t           iload [CPUS];

  logic            gnt_valid;
  logic [1:0]      gnt_id;

  modport master (
    output dREN, dWEN, iREN, daddr, dstore, iaddr, ramstate, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore, dwait, iwait, dload, iload,
           gnt_valid, gnt_id
  );

  modport slave (
    input  dREN, dWEN, iREN, daddr, dstore, iaddr, ramstate, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, dwait, iwait, dload, iload,
           gnt_valid, gnt_id
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-core shared-RAM arbiter: class priority (write > read > fetch), per-class
// round-robin, and a starvation guard that forces a fetch after STARVE_MAX data grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS       = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  ram_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic [1:0] {CL_WR, CL_RD, CL_IF} class_t;

  state_t           state;
  class_t           cls;
  logic             owner;
  logic             ptr_wr;
  logic             ptr_rd;
  logic             ptr_if;
  logic [CNT_W-1:0] starve_cnt;

  logic [CPUS-1:0]  req_wr;
  logic [CPUS-1:0]  req_rd;
  logic [CPUS-1:0]  req_if;
  logic             starved;
  logic             win_valid;
  logic             win_core;
  class_t           win_cls;
  logic             owner_req;
  logic             complete;

  // Favored core is the class pointer; fall back to the other core.
  function automatic logic pick(input logic [CPUS-1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction

  // A core asserting both data strobes is treated as a write.
  assign req_wr  = bus.dWEN;
  assign req_rd  = bus.dREN & ~bus.dWEN;
  assign req_if  = bus.iREN;
  assign starved = (starve_cnt == STARVE_LIM) && (|req_if);

  always_comb begin
    win_valid = 1'b1;
    win_core  = 1'b0;
    win_cls   = CL_WR;
    if (starved) begin
      win_cls  = CL_IF;
      win_core = pick(req_if, ptr_if);
    end else if (|req_wr) begin
      win_cls  = CL_WR;
      win_core = pick(req_wr, ptr_wr);
    end else if (|req_rd) begin
      win_cls  = CL_RD;
      win_core = pick(req_rd, ptr_rd);
    end else if (|req_if) begin
      win_cls  = CL_IF;
      win_core = pick(req_if, ptr_if);
    end else begin
      win_valid = 1'b0;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    case (cls)
      CL_WR:   owner_req = req_wr[owner];
      CL_RD:   owner_req = req_rd[owner];
      CL_IF:   owner_req = req_if[owner];
      default: owner_req = 1'b0;
    endcase
  end

  assign complete = (state == GRANT) && owner_req && (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      cls        <= CL_WR;
      owner      <= 1'b0;
      ptr_wr     <= 1'b0;
      ptr_rd     <= 1'b0;
      ptr_if     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state <= GRANT;
            cls   <= win_cls;
            owner <= win_core;
          end
        end
        GRANT: begin
          // Abort, completion and RAM error all hand the port back to arbitration.
          if (!owner_req || bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            state <= IDLE;
          end
          if (complete) begin
            case (cls)
              CL_WR:   ptr_wr <= ~owner;
              CL_RD:   ptr_rd <= ~owner;
              default: ptr_if <= ~owner;
            endcase
          end
        end
        default: state <= IDLE;
      endcase

      if (!(|req_if)) begin
        starve_cnt <= '0;
      end else if (state == IDLE && win_valid) begin
        if (win_cls == CL_IF) begin
          starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
    end
  end

  // RAM port follows the owner's live request; everything idles low with waits high.
  always_comb begin
    bus.ramREN    = 1'b0;
    bus.ramWEN    = 1'b0;
    bus.ramaddr   = '0;
    bus.ramstore  = '0;
    bus.dwait     = '1;
    bus.iwait     = '1;
    bus.gnt_valid = 1'b0;
    bus.gnt_id    = 2'b00;
    if (state == GRANT) begin
      bus.gnt_valid = 1'b1;
      bus.gnt_id    = {cls == CL_IF, owner};
      bus.ramaddr   = (cls == CL_IF) ? bus.iaddr[owner] : bus.daddr[owner];
      if (cls != CL_IF) begin
        bus.ramstore = bus.dstore[owner];
      end
      bus.ramWEN = (cls == CL_WR) && owner_req;
      bus.ramREN = (cls != CL_WR) && owner_req;
      if (complete) begin
        if (cls == CL_IF) bus.iwait[owner] = 1'b0;
        else              bus.dwait[owner] = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CPUS; c++) begin : g_load
    assign bus.dload[c] = bus.ramload;
    assign bus.iload[c] = bus.ramload;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: write, fairness, priority, starvation,
// abort/error and asynchronous reset scenarios with hand-computed expectations.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.CPUS(2)) bus ();

  ram_arbiter #(.CPUS(2), .STARVE_MAX(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // {ramREN, ramWEN, gnt_valid, gnt_id, dwait[1:0], iwait[1:0]}
  function automatic logic [31:0] pk(input logic ren, input logic wen, input logic gv,
                                     input logic [1:0] gid, input logic [1:0] dw,
                                     input logic [1:0] iw);
    return 32'({ren, wen, gv, gid, dw, iw});
  endfunction

  localparam logic [31:0] IDLE_E = 32'({1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [31:0] exp);
    chk(tag, pk(bus.ramREN, bus.ramWEN, bus.gnt_valid, bus.gnt_id, bus.dwait, bus.iwait), exp);
  endtask

  task automatic clear_inputs();
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iREN     = '0;
    bus.ramstate = FREE;
    for (int c = 0; c < 2; c++) begin
      bus.daddr[c]  = '0;
      bus.dstore[c] = '0;
      bus.iaddr[c]  = '0;
    end
  endtask

  initial begin
    logic c;
    nRST        = 1'b0;
    bus.ramload = '0;
    clear_inputs();
    #2;
    chk_st("reset_state", IDLE_E);
    chk("reset_ramaddr", bus.ramaddr, 32'h0);
    chk("reset_ramstore", bus.ramstore, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK); #1;
    chk_st("idle_noreq", IDLE_E);
    bus.ramload = 32'hCAFE_F00D;
    #1;
    chk("dload1", bus.dload[1], 32'hCAFE_F00D);
    chk("iload0", bus.iload[0], 32'hCAFE_F00D);

    // Single write from core 0
    @(negedge CLK);
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hDEAD_BEEF;
    bus.ramstate = BUSY;
    #1; chk_st("wr_cyc0", IDLE_E);
    @(negedge CLK);
    bus.ramstate = ACCESS;
    #1; chk_st("wr_cyc1", pk(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b11));
    chk("wr_addr", bus.ramaddr, 32'h100);
    chk("wr_store", bus.ramstore, 32'hDEAD_BEEF);
    @(negedge CLK);
    bus.dWEN = '0; bus.ramstate = FREE;
    #1; chk_st("wr_cyc2", IDLE_E);

    // Fairness: both cores read, RAM always ready
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        bus.dREN = 2'b11; bus.daddr[1] = 32'h200; bus.ramstate = ACCESS;
      end
      #1;
      if (n % 2 == 0)
        chk_st($sformatf("fair%0d", n), IDLE_E);
      else if (n == 3) begin
        chk_st($sformatf("fair%0d", n), pk(1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11));
        chk("fair3_addr", bus.ramaddr, 32'h200);
      end else
        chk_st($sformatf("fair%0d", n), pk(1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b11));
    end
    @(negedge CLK);
    bus.dREN = '0; bus.ramstate = FREE;
    #1; chk_st("fair_end", IDLE_E);

    // Class priority: core1 write, core0 read, core0 fetch
    @(negedge CLK);
    bus.dWEN[1] = 1'b1; bus.dREN[0] = 1'b1; bus.iREN[0] = 1'b1;
    bus.iaddr[0] = 32'h400; bus.ramstate = ACCESS;
    #1; chk_st("pri0", IDLE_E);
    @(negedge CLK); #1; chk_st("pri1_wr", pk(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b11));
    @(negedge CLK); bus.dWEN[1] = 1'b0;
    #1; chk_st("pri2", IDLE_E);
    @(negedge CLK); #1; chk_st("pri3_rd", pk(1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b11));
    @(negedge CLK); bus.dREN[0] = 1'b0;
    #1; chk_st("pri4", IDLE_E);
    @(negedge CLK); #1; chk_st("pri5_if", pk(1'b1, 1'b0, 1'b1, 2'b10, 2'b11, 2'b10));
    chk("pri5_addr", bus.ramaddr, 32'h400);
    @(negedge CLK); bus.iREN[0] = 1'b0; bus.ramstate = FREE;
    #1; chk_st("pri6", IDLE_E);

    // Starvation: eight data grants, then core1 fetch is forced through
    for (int n = 0; n < 18; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        bus.dREN = 2'b11; bus.iREN = 2'b10; bus.ramstate = ACCESS;
      end
      #1;
      if (n % 2 == 0)
        chk_st($sformatf("stv%0d", n), IDLE_E);
      else if (n == 17)
        chk_st("stv17_fetch", pk(1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b01));
      else begin
        c = (((n - 1) / 2) % 2 == 0) ? 1'b1 : 1'b0;
        chk_st($sformatf("stv%0d", n),
               pk(1'b1, 1'b0, 1'b1, {1'b0, c}, c ? 2'b01 : 2'b10, 2'b11));
      end
    end
    @(negedge CLK);
    bus.dREN = '0; bus.iREN = '0; bus.ramstate = FREE;
    #1; chk_st("stv_end", IDLE_E);

    // Abort: core1 read stalls three cycles then withdraws
    @(negedge CLK);
    bus.dREN[1] = 1'b1; bus.ramstate = BUSY;
    #1; chk_st("abt0", IDLE_E);
    for (int n = 1; n < 4; n++) begin
      @(negedge CLK); #1;
      chk_st($sformatf("abt%0d", n), pk(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b11));
    end
    @(negedge CLK); bus.dREN[1] = 1'b0;
    #1; chk_st("abt4_drop", pk(1'b0, 1'b0, 1'b1, 2'b01, 2'b11, 2'b11));
    @(negedge CLK); #1; chk_st("abt5", IDLE_E);

    // Error: read pointer still favors core1, which is re-granted after ERROR
    @(negedge CLK);
    bus.dREN = 2'b11; bus.ramstate = ERROR;
    #1; chk_st("err0", IDLE_E);
    @(negedge CLK); #1; chk_st("err1", pk(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b11));
    @(negedge CLK); bus.ramstate = ACCESS;
    #1; chk_st("err2", IDLE_E);
    @(negedge CLK); #1; chk_st("err3_regrant", pk(1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11));
    @(negedge CLK); bus.dREN = '0; bus.ramstate = FREE;
    #1; chk_st("err4", IDLE_E);

    // Reset asserted mid-grant takes effect between clock edges
    @(negedge CLK);
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h300; bus.ramstate = BUSY;
    #1; chk_st("rst0", IDLE_E);
    @(negedge CLK); #1; chk_st("rst1_grant", pk(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b11));
    #2; nRST = 1'b0;
    #1; chk_st("rst_async", IDLE_E);
    chk("rst_async_addr", bus.ramaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1; bus.dREN = 2'b11;
    #1; chk_st("rst_release", IDLE_E);
    @(negedge CLK); #1; chk_st("rst_resume", pk(1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 2'b11));
    @(negedge CLK); clear_inputs();
    #1; chk_st("rst_end_abort", pk(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
